// File: rtl/ame_pkg.sv
// Shared types and constants for the AME normalizer scheduler slice.
package ame_pkg;

  localparam int AME_DATA_BITS = 64;

  typedef enum logic [1:0] {IDLE, CALC, HOLD} ame_sched_state_t;

endpackage

// File: rtl/ame_num_normal.sv
// Combinational sign-magnitude normalizer: shifts the magnitude right and restores the sign,
// so negative results round toward zero. Output is zero unless comp_init_i is set.
module ame_num_normal #(
  parameter int COMP_DATA_BITS = 64
) (
  input  logic                              comp_init_i,
  input  logic [COMP_DATA_BITS-1:0]         comp_data_i,
  input  logic [$clog2(COMP_DATA_BITS)-1:0] comp_shift_i,
  output logic [COMP_DATA_BITS-1:0]         comp_data_o
);

  logic                      w_neg;
  logic [COMP_DATA_BITS-1:0] w_mag;
  logic [COMP_DATA_BITS-1:0] w_shifted;

  // The most-negative value negates to itself; read as unsigned it is the correct magnitude.
  always_comb begin
    w_neg       = comp_data_i[COMP_DATA_BITS-1];
    w_mag       = w_neg ? -comp_data_i : comp_data_i;
    w_shifted   = w_mag >> comp_shift_i;
    comp_data_o = '0;
    if (comp_init_i) begin
      comp_data_o = w_neg ? -w_shifted : w_shifted;
    end
  end

endmodule

// File: rtl/ame_rr_arb.sv
// Combinational round-robin arbiter: grants the first set request at or after the pointer, wrapping.
module ame_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic                       o_grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx
);

  localparam int IW = $clog2(NUM_REQ);

  int w_idx;

  // Scanning from the farthest offset back to the pointer lets the nearest requester win.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_idx         = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = int'(i_ptr) + i;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (i_req[IW'(w_idx)]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/ame_norm_sched.sv
// Round-robin scheduler sharing one ame_num_normal unit between NUM_REQ requesters;
// accepts jobs over valid/ready and returns registered results tagged with the requester id.
module ame_norm_sched
  import ame_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = AME_DATA_BITS,
  parameter int NORM_LAT  = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic [NUM_REQ-1:0]                     req_valid_i,
  output logic [NUM_REQ-1:0]                     req_ready_o,
  input  logic [NUM_REQ*DATA_BITS-1:0]           req_data_i,
  input  logic [NUM_REQ*$clog2(DATA_BITS)-1:0]   req_shift_i,
  output logic                                   rsp_valid_o,
  input  logic                                   rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]             rsp_id_o,
  output logic [DATA_BITS-1:0]                   rsp_data_o,
  output logic                                   busy_o
);

  localparam int SW = $clog2(DATA_BITS);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (NORM_LAT > 1) ? $clog2(NORM_LAT) : 1;

  ame_sched_state_t r_state;
  ame_sched_state_t w_next_state;

  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_id;
  logic [CW-1:0]        r_cnt;
  logic [DATA_BITS-1:0] r_data;
  logic [SW-1:0]        r_shift;
  logic                 r_rsp_valid;
  logic [IW-1:0]        r_rsp_id;
  logic [DATA_BITS-1:0] r_rsp_data;

  logic                 w_grant_valid;
  logic [IW-1:0]        w_grant_idx;
  logic [DATA_BITS-1:0] w_norm_data;
  logic                 w_accept;
  logic                 w_capture;
  logic                 w_rsp_fire;
  logic                 w_comp_init;

  ame_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req         (req_valid_i),
    .i_ptr         (r_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  ame_num_normal #(
    .COMP_DATA_BITS (DATA_BITS)
  ) u_norm (
    .comp_init_i  (w_comp_init),
    .comp_data_i  (r_data),
    .comp_shift_i (r_shift),
    .comp_data_o  (w_norm_data)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Ready is also gated by reset so no transfer is offered while the block is held in reset.
  always_comb begin
    w_next_state = r_state;
    req_ready_o  = '0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_rsp_fire   = 1'b0;
    w_comp_init  = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n_i && w_grant_valid) begin
          req_ready_o[w_grant_idx] = 1'b1;
          w_accept                 = 1'b1;
          w_next_state             = CALC;
        end
      end
      CALC: begin
        w_comp_init = 1'b1;
        if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready_i) begin
          w_rsp_fire   = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_data      <= '0;
      r_shift     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_accept) begin
        r_data  <= req_data_i[int'(w_grant_idx)*DATA_BITS +: DATA_BITS];
        r_shift <= req_shift_i[int'(w_grant_idx)*SW +: SW];
        r_id    <= w_grant_idx;
        r_cnt   <= CW'(NORM_LAT - 1);
        r_ptr   <= (w_grant_idx == IW'(NUM_REQ - 1)) ? '0 : w_grant_idx + IW'(1);
      end else if (r_state == CALC && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_data  <= w_norm_data;
      end else if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_data_o  = r_rsp_data;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_ame_norm_sched.sv
// Self-checking bench for ame_norm_sched: directed scenarios plus a randomized run against
// a transaction-level model (round-robin choice, divide-toward-zero arithmetic).
module tb_ame_norm_sched;

  localparam int NR = 4;
  localparam int DB = 64;
  localparam int SW = 6;
  localparam int IW = 2;
  localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic [NR-1:0]   req_valid_i;
  logic [NR-1:0]   req_ready_o;
  logic [NR*DB-1:0] req_data_i;
  logic [NR*SW-1:0] req_shift_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [IW-1:0]   rsp_id_o;
  logic [DB-1:0]   rsp_data_o;
  logic            busy_o;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk_i = ~clk_i;

  ame_norm_sched #(
    .NUM_REQ   (NR),
    .DATA_BITS (DB),
    .NORM_LAT  (1)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i),
    .req_shift_i (req_shift_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_data_o  (rsp_data_o),
    .busy_o      (busy_o)
  );

  // Result = x / 2^s truncated toward zero; s=63 handled separately to avoid the sign bit.
  function automatic logic [63:0] refNorm(input logic [63:0] x, input int s);
    longint sx;
    longint q;
    sx = longint'(x);
    if (s >= 63) q = (x == MOST_NEG) ? -64'sd1 : 64'sd0;
    else         q = sx / (longint'(1) << s);
    return q;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic setReq(input int k, input logic v, input logic [63:0] d, input int s);
    req_valid_i[k]           = v;
    req_data_i[k*DB +: DB]   = d;
    req_shift_i[k*SW +: SW]  = s[SW-1:0];
  endtask

  task automatic doReset();
    rst_n_i     = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    req_shift_i = '0;
    rsp_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  // Drives one job on requester k and returns what was observed; starts and ends in an idle cycle.
  task automatic runJob(input int k, input logic [63:0] d, input int s,
                        output logic [NR-1:0] rdy, output logic v,
                        output logic [IW-1:0] id, output logic [63:0] data);
    setReq(k, 1'b1, d, s);
    @(negedge clk_i);
    rdy = req_ready_o;
    tick();
    setReq(k, 1'b0, '0, 0);
    tick();
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    v    = rsp_valid_o;
    id   = rsp_id_o;
    data = rsp_data_o;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i     = 1'b0;
    req_valid_i = '1;
    req_data_i  = '0;
    req_shift_i = '0;
    rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    nChecks++;
    if ({req_ready_o, rsp_valid_o, rsp_id_o, busy_o} !== '0 || rsp_data_o !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: ready=%b valid=%b id=%0d busy=%b data=%h, required all zero",
               req_ready_o, rsp_valid_o, rsp_id_o, busy_o, rsp_data_o);
    end
    doReset();
    @(negedge clk_i);
    nChecks++;
    if ({req_ready_o, rsp_valid_o, busy_o} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_idle: ready=%b valid=%b busy=%b, required zero", req_ready_o, rsp_valid_o, busy_o);
    end
    tick();
  endtask

  task automatic test_single();
    doReset();
    setReq(0, 1'b1, 64'd100, 2);
    @(negedge clk_i);
    nChecks++;
    if (req_ready_o !== 4'b0001) begin
      nFails++;
      $display("[TB] FAIL single_ready: got %b required 0001", req_ready_o);
    end
    tick();
    setReq(0, 1'b0, '0, 0);
    @(negedge clk_i);
    nChecks++;
    if (rsp_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL single_calc: valid=%b busy=%b required valid=0 busy=1", rsp_valid_o, busy_o);
    end
    tick();
    @(negedge clk_i);
    nChecks++;
    if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd0 || rsp_data_o !== 64'd25) begin
      nFails++;
      $display("[TB] FAIL single_rsp: valid=%b id=%0d data=%0d required 1/0/25", rsp_valid_o, rsp_id_o, rsp_data_o);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    @(negedge clk_i);
    nChecks++;
    if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL single_release: valid=%b busy=%b required 0/0", rsp_valid_o, busy_o);
    end
    tick();
  endtask

  task automatic test_negative();
    logic [NR-1:0] rdy;
    logic          v;
    logic [IW-1:0] id;
    logic [63:0]   data;
    doReset();
    runJob(2, 64'hFFFF_FFFF_FFFF_FFFB, 1, rdy, v, id, data);
    nChecks++;
    if (rdy !== 4'b0100 || v !== 1'b1 || id !== 2'd2 || data !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      nFails++;
      $display("[TB] FAIL negative_round: ready=%b valid=%b id=%0d data=%h required 0100/1/2/fffffffffffffffe",
               rdy, v, id, data);
    end
  endtask

  task automatic test_fairness();
    logic [63:0] d[NR];
    int          s[NR];
    int          expId[$];
    logic [63:0] expData[$];
    int          nGrant;
    int          nRsp;
    int          g;
    doReset();
    rsp_ready_i = 1'b1;
    for (int k = 0; k < NR; k++) begin
      d[k] = rand64();
      s[k] = $urandom_range(0, 63);
      setReq(k, 1'b1, d[k], s[k]);
    end
    nGrant = 0;
    nRsp   = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk_i);
      g = -1;
      for (int k = 0; k < NR; k++) if (req_ready_o[k]) g = k;
      if (req_ready_o !== '0) begin
        nChecks++;
        if ($countones(req_ready_o) != 1 || g != (nGrant % NR) || c != 3 * nGrant) begin
          nFails++;
          $display("[TB] FAIL fair_grant: cycle %0d ready=%b, required grant %0d at cycle %0d",
                   c, req_ready_o, nGrant % NR, 3 * nGrant);
        end
        expId.push_back(g);
        expData.push_back(refNorm(d[g], s[g]));
        nGrant++;
      end
      if (rsp_valid_o === 1'b1) begin
        nChecks++;
        if (expId.size() == 0) begin
          nFails++;
          $display("[TB] FAIL fair_rsp: unexpected response id=%0d at cycle %0d", rsp_id_o, c);
        end else begin
          if (int'(rsp_id_o) != expId[0] || rsp_data_o !== expData[0]) begin
            nFails++;
            $display("[TB] FAIL fair_rsp: id=%0d data=%h required id=%0d data=%h",
                     rsp_id_o, rsp_data_o, expId[0], expData[0]);
          end
          void'(expId.pop_front());
          void'(expData.pop_front());
        end
        nRsp++;
      end
      tick();
      if (g >= 0) begin
        d[g] = rand64();
        s[g] = $urandom_range(0, 63);
        setReq(g, 1'b1, d[g], s[g]);
      end
    end
    nChecks++;
    if (nGrant != 6 || nRsp != 6) begin
      nFails++;
      $display("[TB] FAIL fair_count: grants=%0d responses=%0d required 6/6", nGrant, nRsp);
    end
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    logic [63:0] d0;
    logic [63:0] d1;
    int          s0;
    int          s1;
    doReset();
    d0 = rand64(); s0 = $urandom_range(0, 63);
    d1 = rand64(); s1 = $urandom_range(0, 63);
    setReq(0, 1'b1, d0, s0);
    @(negedge clk_i);
    nChecks++;
    if (req_ready_o !== 4'b0001) begin
      nFails++;
      $display("[TB] FAIL bp_accept0: ready=%b required 0001", req_ready_o);
    end
    tick();
    setReq(0, 1'b0, '0, 0);
    setReq(1, 1'b1, d1, s1);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk_i);
      nChecks++;
      if (req_ready_o !== '0 || (c > 0 && (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd0 ||
                                            rsp_data_o !== refNorm(d0, s0)))) begin
        nFails++;
        $display("[TB] FAIL bp_hold: cycle %0d ready=%b valid=%b id=%0d data=%h required ready=0 valid=1 id=0 data=%h",
                 c, req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, refNorm(d0, s0));
      end
      tick();
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    nChecks++;
    if (req_ready_o !== '0 || rsp_valid_o !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL bp_handshake: ready=%b valid=%b required 0000/1", req_ready_o, rsp_valid_o);
    end
    tick();
    rsp_ready_i = 1'b0;
    @(negedge clk_i);
    nChecks++;
    if (req_ready_o !== 4'b0010 || rsp_valid_o !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL bp_accept1: ready=%b valid=%b required 0010/0", req_ready_o, rsp_valid_o);
    end
    tick();
    setReq(1, 1'b0, '0, 0);
    tick();
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    nChecks++;
    if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd1 || rsp_data_o !== refNorm(d1, s1)) begin
      nFails++;
      $display("[TB] FAIL bp_rsp1: valid=%b id=%0d data=%h required 1/1/%h",
               rsp_valid_o, rsp_id_o, rsp_data_o, refNorm(d1, s1));
    end
    tick();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_wrap();
    logic [NR-1:0] rdy;
    logic          v;
    logic [IW-1:0] id;
    logic [63:0]   data;
    doReset();
    for (int k = 0; k < 3; k++) runJob(k, 64'd8, 1, rdy, v, id, data);
    rsp_ready_i = 1'b1;
    setReq(1, 1'b1, 64'd40, 3);
    setReq(3, 1'b1, 64'd64, 4);
    @(negedge clk_i);
    nChecks++;
    if (req_ready_o !== 4'b1000) begin
      nFails++;
      $display("[TB] FAIL wrap_first: ready=%b required 1000", req_ready_o);
    end
    tick();
    setReq(3, 1'b0, '0, 0);
    tick();
    tick();
    @(negedge clk_i);
    nChecks++;
    if (req_ready_o !== 4'b0010) begin
      nFails++;
      $display("[TB] FAIL wrap_second: ready=%b required 0010", req_ready_o);
    end
    tick();
    setReq(1, 1'b0, '0, 0);
    tick();
    tick();
    rsp_ready_i = 1'b0;
    runJob(0, MOST_NEG, 0, rdy, v, id, data);
    nChecks++;
    if (v !== 1'b1 || data !== MOST_NEG) begin
      nFails++;
      $display("[TB] FAIL most_neg_s0: valid=%b data=%h required 1/%h", v, data, MOST_NEG);
    end
    runJob(2, MOST_NEG, 63, rdy, v, id, data);
    nChecks++;
    if (v !== 1'b1 || id !== 2'd2 || data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      nFails++;
      $display("[TB] FAIL most_neg_s63: valid=%b id=%0d data=%h required 1/2/ffffffffffffffff", v, id, data);
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    setReq(0, 1'b1, 64'd1000, 1);
    @(negedge clk_i);
    nChecks++;
    if (req_ready_o !== 4'b0001) begin
      nFails++;
      $display("[TB] FAIL rmid_accept: ready=%b required 0001", req_ready_o);
    end
    tick();
    setReq(0, 1'b1, 64'd300, 2);
    setReq(3, 1'b1, 64'd77, 0);
    #1 rst_n_i = 1'b0;
    #1;
    nChecks++;
    if ({req_ready_o, rsp_valid_o, rsp_id_o, busy_o} !== '0 || rsp_data_o !== '0) begin
      nFails++;
      $display("[TB] FAIL rmid_outputs: ready=%b valid=%b id=%0d busy=%b data=%h required all zero",
               req_ready_o, rsp_valid_o, rsp_id_o, busy_o, rsp_data_o);
    end
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(negedge clk_i);
    nChecks++;
    if (req_ready_o !== 4'b0001) begin
      nFails++;
      $display("[TB] FAIL rmid_regrant: ready=%b required 0001", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    tick();
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    nChecks++;
    if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd0 || rsp_data_o !== 64'd75) begin
      nFails++;
      $display("[TB] FAIL rmid_rsp: valid=%b id=%0d data=%0d required 1/0/75", rsp_valid_o, rsp_id_o, rsp_data_o);
    end
    tick();
    rsp_ready_i = 1'b0;
  endtask

  // Model: one job at a time; grant only when nothing is in flight; response appears two
  // cycles after accept and the block is free again the cycle after the response handshake.
  task automatic test_random();
    logic [63:0]   d[NR];
    int            s[NR];
    int            ptr;
    bit            inFlight;
    int            acceptC;
    int            expId;
    logic [63:0]   expData;
    logic [NR-1:0] expReady;
    bit            expValid;
    bit            freeNext;
    int            g;
    doReset();
    ptr      = 0;
    inFlight = 0;
    acceptC  = 0;
    expId    = 0;
    expData  = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NR; k++) begin
        if (!req_valid_i[k] && $urandom_range(0, 2) == 0) begin
          d[k] = rand64();
          s[k] = $urandom_range(0, 63);
          setReq(k, 1'b1, d[k], s[k]);
        end else if (req_valid_i[k] && $urandom_range(0, 9) == 0) begin
          setReq(k, 1'b0, '0, 0);
        end
      end
      rsp_ready_i = 1'($urandom_range(0, 1));
      expReady = '0;
      g = -1;
      if (!inFlight) begin
        for (int o = NR - 1; o >= 0; o--) if (req_valid_i[(ptr + o) % NR]) g = (ptr + o) % NR;
        if (g >= 0) expReady[g] = 1'b1;
      end
      expValid = inFlight && (c >= acceptC + 2);
      @(negedge clk_i);
      nChecks++;
      if (req_ready_o !== expReady || rsp_valid_o !== expValid) begin
        nFails++;
        $display("[TB] FAIL rand_ctrl: cycle %0d ready=%b valid=%b required ready=%b valid=%b",
                 c, req_ready_o, rsp_valid_o, expReady, expValid);
      end
      freeNext = 0;
      if (expValid && rsp_ready_i) begin
        nChecks++;
        if (int'(rsp_id_o) != expId || rsp_data_o !== expData) begin
          nFails++;
          $display("[TB] FAIL rand_rsp: cycle %0d id=%0d data=%h required id=%0d data=%h",
                   c, rsp_id_o, rsp_data_o, expId, expData);
        end
        freeNext = 1;
      end
      if (g >= 0) begin
        inFlight = 1;
        acceptC  = c;
        expId    = g;
        expData  = refNorm(d[g], s[g]);
        ptr      = (g + 1) % NR;
      end
      tick();
      if (freeNext) inFlight = 0;
      if (g >= 0) setReq(g, 1'b0, '0, 0);
    end
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    repeat (4) tick();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_negative();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
